// File: rtl/peridot_phy_uart_pkg.sv
// Shared definitions for the PERIDOT UART PHYs (transmitter and receiver).
// Holds the bit-period helpers, the frame state enum and the framing constants.
package peridot_phy_uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned DIV_WIDTH = 12;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Reload value for the bit-period down-counter (bit period minus one).
  function automatic logic [DIV_WIDTH-1:0] calc_div_m1(input int unsigned freq,
                                                       input int unsigned baud);
    int unsigned div;
    div = freq / baud;
    return DIV_WIDTH'(div - 1);
  endfunction

  // True when the bit period fits the divider: 2 .. 2**DIV_WIDTH clocks.
  function automatic bit div_in_range(input int unsigned freq, input int unsigned baud);
    int unsigned div;
    div = freq / baud;
    return (div >= 2) && (div <= (1 << DIV_WIDTH));
  endfunction

endpackage

// File: rtl/peridot_uart_baud_tick.sv
// Reloadable bit-period down-counter for the UART PHYs.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset (counter cleared to 0)
//   restart - reload the counter, aligning bit boundaries to a frame start
//   tick    - high for the last clock of each bit period (counter at 0)
module peridot_uart_baud_tick
  import peridot_phy_uart_pkg::*;
#(
  parameter logic [DIV_WIDTH-1:0] Reload = DIV_WIDTH'(9)
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - DIV_WIDTH'(1);
    if (restart || (cnt_q == '0)) begin
      cnt_d = Reload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/peridot_phy_txd.sv
// UART transmitter PHY: 8 data bits LSB first, 1 or 2 stop bits, fixed baud.
// A one-entry holding register accepts the next byte while the current frame
// shifts out, so back-to-back frames have no idle gap.
// Optional parity bit is built when PERIDOT_PHY_TXD_PARITY_EN is defined.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset
//   in_ready - sink ready (holding register empty)
//   in_valid - sink valid
//   in_data  - byte to send
//   txd      - registered serial output, idles high
//   tx_busy  - frame in progress or holding register full
module peridot_phy_txd
  import peridot_phy_uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned UART_BAUDRATE   = 115200,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned PARITY_ODD      = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       txd,
  output logic       tx_busy
);

  localparam logic [DIV_WIDTH-1:0] DivM1 = calc_div_m1(CLOCK_FREQUENCY, UART_BAUDRATE);

  if (!div_in_range(CLOCK_FREQUENCY, UART_BAUDRATE)) begin : g_bad_div
    $error("peridot_phy_txd: bit period must be 2..4096 clocks");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("peridot_phy_txd: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("peridot_phy_txd: PARITY_ODD must be 0 or 1");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_data_q;
  logic        hold_valid_q, hold_valid_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;  // extra stop bits still to send
  logic        txd_q, txd_d;
  logic        tick, restart, accept, stop_end, launch;
`ifdef PERIDOT_PHY_TXD_PARITY_EN
  logic        parity_q, parity_d;
`endif

  peridot_uart_baud_tick #(
    .Reload (DivM1)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign accept   = in_valid && !hold_valid_q;
  assign stop_end = (state_q == StStop) && tick && !stop_cnt_q;
  // Start a frame from idle, or chain straight from the final stop bit.
  assign launch   = hold_valid_q && ((state_q == StIdle) || stop_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      txd_q        <= 1'b1;
`ifdef PERIDOT_PHY_TXD_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_valid_q <= hold_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      txd_q        <= txd_d;
      if (accept) begin
        hold_data_q <= in_data;
      end
`ifdef PERIDOT_PHY_TXD_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (hold_valid_q) state_d = StStart;
      StStart:  if (tick) state_d = StData;
      StData: begin
        if (tick && (bit_cnt_q == '0)) begin
`ifdef PERIDOT_PHY_TXD_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
      StParity: if (tick) state_d = StStop;
      StStop:   if (stop_end) state_d = hold_valid_q ? StStart : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_d      = shift_q;
    hold_valid_d = hold_valid_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    txd_d        = txd_q;
    restart      = 1'b0;
`ifdef PERIDOT_PHY_TXD_PARITY_EN
    parity_d     = parity_q;
`endif
    if (accept) begin
      hold_valid_d = 1'b1;
    end
    if (launch) begin
      shift_d      = hold_data_q;
      hold_valid_d = 1'b0;
      txd_d        = 1'b0;
      restart      = 1'b1;
`ifdef PERIDOT_PHY_TXD_PARITY_EN
      parity_d     = (^hold_data_q) ^ PARITY_ODD[0];
`endif
    end else if (tick) begin
      unique case (state_q)
        StStart: begin
          txd_d     = shift_q[0];
          bit_cnt_d = 3'(DATA_BITS - 1);
        end
        StData: begin
          if (bit_cnt_q != '0) begin
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else begin
`ifdef PERIDOT_PHY_TXD_PARITY_EN
            txd_d      = parity_q;
`else
            txd_d      = 1'b1;
            stop_cnt_d = (STOP_BITS == 2);
`endif
          end
        end
        StParity: begin
          txd_d      = 1'b1;
          stop_cnt_d = (STOP_BITS == 2);
        end
        StStop: begin
          if (stop_cnt_q) stop_cnt_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    txd      = txd_q;
    in_ready = !hold_valid_q;
    tx_busy  = (state_q != StIdle) || hold_valid_q;
  end

endmodule
